// File: rtl/serial_half_sub_fsm_if.sv
// ---------------------------------------------------------------------------
// serial_half_sub_fsm_if
// Handshake and data bundle for the bit-serial subtractor.
//   start      : request, sampled only while the subtractor is idle
//   a_in       : minuend, captured on the accepted start edge
//   b_in       : subtrahend, captured on the accepted start edge
//   busy       : high while shifting and during the done cycle
//   done       : one-cycle pulse, diff/borrow_out valid
//   diff       : a_in - b_in modulo 2^WIDTH
//   borrow_out : final borrow, 1 when a_in < b_in (unsigned)
// Modports: master drives requests, slave (the subtractor) answers.
// ---------------------------------------------------------------------------
interface serial_half_sub_fsm_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a_in, b_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_half_sub_fsm.sv
// ---------------------------------------------------------------------------
// serial_half_sub_fsm
// Bit-serial subtractor: diff = a_in - b_in, LSB first, one bit per clock,
// using a single half-subtractor cell with the borrow held in a flop.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_half_sub_fsm_if.slave (start/a_in/b_in in,
//           busy/done/diff/borrow_out out)
// Timing: start accepted at edge N, done high in the cycle after edge
// N+WIDTH; one operation at most every WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module serial_half_sub_fsm #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_half_sub_fsm_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One half-subtractor step: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] half_sub_cell(
    input logic a,
    input logic b,
    input logic br
  );
    logic d;
    logic br_next;
    d       = a ^ b ^ br;
    br_next = (~a & b) | (~(a ^ b) & br);
    return {br_next, d};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_sh_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] diff_next_s;

  // Current cell result and the diff shift register after this bit lands.
  always_comb begin
    cell_s      = half_sub_cell(a_sh_r[0], b_sh_r[0], br_r);
    diff_next_s = {cell_s[0], diff_sh_r[WIDTH-1:1]};
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      a_sh_r       <= '0;
      b_sh_r       <= '0;
      diff_sh_r    <= '0;
      br_r         <= 1'b0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diff_r       <= '0;
      borrow_out_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r       <= bus.a_in;
            b_sh_r       <= bus.b_in;
            diff_sh_r    <= '0;
            br_r         <= 1'b0;
            cnt_r        <= '0;
            busy_r       <= 1'b1;
            // A new result is being built; the old one is withdrawn.
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
            state_r      <= S_SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_SHIFT: begin
          a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
          diff_sh_r <= diff_next_s;
          br_r      <= cell_s[1];
          cnt_r     <= cnt_r + CW'(1);
          // Old count WIDTH-1 means this edge processes the MSB.
          if (cnt_r == CW'(WIDTH - 1)) begin
            diff_r       <= diff_next_s;
            borrow_out_r <= cell_s[1];
            done_r       <= 1'b1;
            state_r      <= S_DONE;
          end else begin
            state_r <= S_SHIFT;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_out_r;

endmodule
